// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  // Frame layout shared with the transmitter.
  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // One-hot receiver states.
  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    START = 4'b0010,
    DATA  = 4'b0100,
    STOP  = 4'b1000
  } state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Serial receive bundle: raw line in, received byte and status out.
// Latency: n/a (wires only).
// Backpressure: none; rx_valid/frame_err are single-cycle pulses with no ready.
// Ports: rx (serial line), data (last good byte), rx_valid, rx_busy, frame_err.
interface uart_rx_if;
  import uart_pkg::*;

  logic                 rx;
  logic [DATA_BITS-1:0] data;
  logic                 rx_valid;
  logic                 rx_busy;
  logic                 frame_err;

  // Receiver side.
  modport master (
    input  rx,
    output data, rx_valid, rx_busy, frame_err
  );

  // Line driver / consumer side.
  modport slave (
    output rx,
    input  data, rx_valid, rx_busy, frame_err
  );
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Latency: 2 clk cycles from d to q.
// Backpressure: none.
// Ports: clk, rst (sync, active-high), d (async in), q (synchronized out).
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames with inverted payload, mid-bit sampling.
// Latency: rx_valid/frame_err pulse 1 clk after the mid-stop-bit sample.
// Backpressure: none; the consumer must take data on the rx_valid pulse.
// Ports: clk, rst (sync, active-high), bus (uart_rx_if.master).
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_RATE   = 115_200,
  parameter int CLOCK_SPEED = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  uart_rx_if.master  bus
);

  localparam int BAUD_WIDTH = CLOCK_SPEED / BAUD_RATE;
  localparam int HALF_WIDTH = BAUD_WIDTH / 2;
  localparam int CNT_W      = $clog2(BAUD_WIDTH);
  localparam int IDX_W      = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_WIDTH - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  state_t               state, state_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic [IDX_W-1:0]     idx, idx_next;
  logic [DATA_BITS-1:0] shreg, shreg_next;
  logic [DATA_BITS-1:0] data, data_next;
  logic                 valid, valid_next;
  logic                 err, err_next;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start.
  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      data  <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
      shreg <= shreg_next;
      data  <= data_next;
      valid <= valid_next;
      err   <= err_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt + CNT_W'(1);
    idx_next   = idx;
    shreg_next = shreg;
    data_next  = data;
    valid_next = 1'b0;
    err_next   = 1'b0;

    case (state)
      IDLE: begin
        cnt_next = '0;
        if (rx_s == START_BIT) state_next = START;
      end

      // Wait half a bit so every later sample lands mid-bit; a line that
      // is high again by then was a glitch and is dropped silently.
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_next = '0;
          if (rx_s == START_BIT) begin
            state_next = DATA;
            idx_next   = '0;
          end else begin
            state_next = IDLE;
          end
        end
      end

      DATA: begin
        if (cnt == BAUD_LAST) begin
          cnt_next        = '0;
          shreg_next[idx] = rx_s;
          idx_next        = idx + IDX_W'(1);
          if (idx == IDX_LAST) state_next = STOP;
        end
      end

      // Leaving at mid-stop-bit leaves half a bit of slack to catch a
      // back-to-back start edge. Payload travels inverted on the line.
      STOP: begin
        if (cnt == BAUD_LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
          if (rx_s == STOP_BIT) begin
            data_next  = ~shreg;
            valid_next = 1'b1;
          end else begin
            err_next   = 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        idx_next   = '0;
      end
    endcase
  end

  assign bus.data      = data;
  assign bus.rx_valid  = valid;
  assign bus.frame_err = err;
  assign bus.rx_busy   = (state != IDLE);

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter BAUD_RATE, default 115_200, line bit rate in bits/s.
REQ-002 Parameter CLOCK_SPEED, default 50_000_000, clk frequency in Hz.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 rx  input  1  asynchronous serial line; idle high.
REQ-006 data  output  8  last correctly framed received byte.
REQ-007 rx_valid  output  1  one-cycle pulse; data holds a new byte.
REQ-008 rx_busy  output  1  high while a frame is in progress (any state other than IDLE).
REQ-009 frame_err  output  1  one-cycle pulse; stop bit sampled low.

Function
REQ-010 Frame format SHALL be 1 start bit (0), 8 payload bits LSB first, 1 stop bit (1); payload bits on the line SHALL be the bitwise complement of the byte; uart_rx SHALL re-complement them so data equals the transmitted byte.
REQ-011 BAUD_WIDTH SHALL be CLOCK_SPEED/BAUD_RATE (integer division, 434 at defaults); HALF_WIDTH SHALL be BAUD_WIDTH/2 (217).
REQ-012 rx SHALL pass through a 2-flop synchronizer before any use; all sampling SHALL use the synchronized value rx_s.
REQ-013 The bit counter SHALL be $clog2(BAUD_WIDTH) bits wide and SHALL clear on every state transition.
REQ-014 States: IDLE, START, DATA, STOP, one-hot encoded.
REQ-015 IDLE: on rx_s == 0 SHALL go to START with counter 0; otherwise remain.
REQ-016 START: counter SHALL count to HALF_WIDTH-1, then sample rx_s; 0 -> DATA with bit index 0; 1 -> IDLE (glitch rejected, no output pulse).
REQ-017 DATA: counter SHALL count to BAUD_WIDTH-1, then sample rx_s into shift register bit [bit index], increment index; after index 7 is sampled, go to STOP.
REQ-018 STOP: counter SHALL count to BAUD_WIDTH-1, then sample rx_s; 1 -> data <= ~shift register, rx_valid = 1 for the next cycle; 0 -> frame_err = 1 for the next cycle, data unchanged; both go to IDLE.
REQ-019 Return to IDLE SHALL occur at mid-stop-bit so a back-to-back start bit is detected with no lost frame.
REQ-020 rx_valid and frame_err SHALL never assert in the same cycle and SHALL each be exactly one cycle wide.
REQ-021 data SHALL hold its value until the next valid frame completes.
REQ-022 Unreachable state encodings SHALL transition to IDLE.

Reset
REQ-023 When rst is high at a clock edge: state IDLE, counter 0, bit index 0, shift register 0, synchronizer flops 1, data 0x00, rx_valid 0, rx_busy 0, frame_err 0.
REQ-024 rst asserted mid-frame SHALL abandon the frame with no rx_valid or frame_err pulse; reception SHALL resume on the next falling edge after rst deasserts.

Structure
REQ-025 Package uart_pkg SHALL hold the state enum (IDLE/START/DATA/STOP one-hot) and the frame constants (8 data bits, start/stop bit values) shared with the transmitter.
REQ-026 The 2-flop synchronizer SHALL be a sub-module sync_2ff (parameter reset value, default 1).
REQ-027 BAUD_WIDTH and HALF_WIDTH SHALL be derived locally from the module parameters.

Verification
REQ-028 Byte 0xA5 sent at 115_200 (line payload 0x5A LSB first: 0,1,0,1,1,0,1,0) -> data = 0xA5, single rx_valid pulse, frame_err stays 0.
REQ-029 Frames for 0x00 and 0xFF sent back-to-back, stop bit exactly one bit time -> two rx_valid pulses, data 0x00 then 0xFF.
REQ-030 rx low for 100 clk then high -> state returns to IDLE after the START sample, no rx_valid or frame_err, rx_busy low again.
REQ-031 Frame for 0x3C with stop bit driven 0 -> frame_err pulses once, data keeps previous value 0xA5.
REQ-032 rst asserted during bit 4 of a frame for 0x81 -> no pulses, outputs at reset values; a following frame for 0x81 -> data = 0x81, rx_valid once.
REQ-033 Sender clock offset of +/-2% on a frame for 0x55 -> data = 0x55 received correctly.
